// File: rtl/amo_sequencer.sv
// amo_sequencer: multi-cycle read-modify-write sequencer for RV32A AMO
// instructions. Borrows the shared ALU while busy and owns the data-memory
// port (with bus lock) from the read through the write.
module amo_sequencer #(
   parameter int ALU_CTRL_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4:0]            funct5,
   input  logic [31:0]           addr,
   input  logic [31:0]           rs2_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [31:0]           rd_data,
   output logic [31:0]           alu_a,
   output logic [31:0]           alu_b,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   input  logic [31:0]           alu_result,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic                  mem_lock,
   output logic [31:0]           mem_addr,
   output logic [3:0]            mem_wstrb,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   // ALU operation codes (mirror of the shared riscv_defines.vh values)
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_ADD_ADDI = ALU_CTRL_W'(0);
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_XOR_XORI = ALU_CTRL_W'(4);
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_OR_ORI   = ALU_CTRL_W'(6);
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_AND_ANDI = ALU_CTRL_W'(7);
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_LUI      = ALU_CTRL_W'(10);
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_MIN      = ALU_CTRL_W'(11);
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_MAX      = ALU_CTRL_W'(12);
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_MINU     = ALU_CTRL_W'(13);
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_MAXU     = ALU_CTRL_W'(14);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_CALC  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Returns {legal, alu code}; SWAP uses the pass-b (LUI) operation.
   function automatic logic [ALU_CTRL_W:0] decode_amo(input logic [4:0] f5);
      logic [ALU_CTRL_W:0] v;
      case (f5)
         5'b00001: v = {1'b1, ALU_CTRL_LUI};
         5'b00000: v = {1'b1, ALU_CTRL_ADD_ADDI};
         5'b00100: v = {1'b1, ALU_CTRL_XOR_XORI};
         5'b01100: v = {1'b1, ALU_CTRL_AND_ANDI};
         5'b01000: v = {1'b1, ALU_CTRL_OR_ORI};
         5'b10000: v = {1'b1, ALU_CTRL_MIN};
         5'b10100: v = {1'b1, ALU_CTRL_MAX};
         5'b11000: v = {1'b1, ALU_CTRL_MINU};
         5'b11100: v = {1'b1, ALU_CTRL_MAXU};
         default:  v = {(ALU_CTRL_W + 1){1'b0}};
      endcase
      return v;
   endfunction

   state_t                  r_state;
   state_t                  w_next_state;
   logic [29:0]             r_addr_word;
   logic [31:0]             r_rs2;
   logic [31:0]             r_old;
   logic [31:0]             r_new;
   logic [ALU_CTRL_W-1:0]   r_ctrl;
   logic                    r_err_flag;
   logic [31:0]             r_rd_data;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_err;
   logic                    r_mem_valid;
   logic                    r_mem_lock;
   logic [3:0]              r_mem_wstrb;

   logic [ALU_CTRL_W:0]     w_decode;
   logic [ALU_CTRL_W-1:0]   w_ctrl;
   logic                    w_bad;

   assign w_decode = decode_amo(funct5);
   assign w_ctrl   = w_decode[ALU_CTRL_W-1:0];
   assign w_bad    = !w_decode[ALU_CTRL_W] || (addr[1:0] != 2'b00);

   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign rd_data   = r_rd_data;
   assign alu_a     = r_old;
   assign alu_b     = r_rs2;
   assign alu_ctrl  = r_ctrl;
   assign mem_valid = r_mem_valid;
   assign mem_lock  = r_mem_lock;
   assign mem_addr  = {r_addr_word, 2'b00};
   assign mem_wstrb = r_mem_wstrb;
   assign mem_wdata = r_new;

   // Next-state decision; mem_ready only matters while a request is up.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_bad) begin
                  w_next_state = S_DONE;
               end else begin
                  w_next_state = S_READ;
               end
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_READ: begin
            if (mem_ready) begin
               w_next_state = S_CALC;
            end else begin
               w_next_state = S_READ;
            end
         end
         S_CALC:  w_next_state = S_WRITE;
         S_WRITE: begin
            if (mem_ready) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_WRITE;
            end
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // State, datapath registers and next-state-derived registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_addr_word <= 30'd0;
         r_rs2       <= 32'd0;
         r_old       <= 32'd0;
         r_new       <= 32'd0;
         r_ctrl      <= {ALU_CTRL_W{1'b0}};
         r_err_flag  <= 1'b0;
         r_rd_data   <= 32'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_mem_valid <= 1'b0;
         r_mem_lock  <= 1'b0;
         r_mem_wstrb <= 4'h0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_addr_word <= addr[31:2];
                  r_rs2       <= rs2_data;
                  r_ctrl      <= w_ctrl;
                  r_err_flag  <= w_bad;
                  r_old       <= 32'd0;
                  r_new       <= 32'd0;
                  if (w_bad) begin
                     r_rd_data <= 32'd0;
                  end
               end
            end
            S_READ: begin
               if (mem_ready) begin
                  r_old <= mem_rdata;
               end
            end
            S_CALC: r_new <= alu_result;
            S_WRITE: begin
               if (mem_ready) begin
                  r_rd_data <= r_old;
               end
            end
            default: ;
         endcase
         r_busy      <= (w_next_state != S_IDLE);
         r_done      <= (w_next_state == S_DONE);
         r_err       <= (w_next_state == S_DONE) &&
                        ((r_state == S_IDLE) ? w_bad : r_err_flag);
         r_mem_valid <= (w_next_state == S_READ) || (w_next_state == S_WRITE);
         r_mem_lock  <= (w_next_state == S_READ) || (w_next_state == S_CALC) ||
                        (w_next_state == S_WRITE);
         r_mem_wstrb <= (w_next_state == S_WRITE) ? 4'hF : 4'h0;
      end
   end

endmodule

// File: tb/tb_amo_sequencer.sv
// Self-checking bench for amo_sequencer: behavioural ALU and memory models,
// an AMO reference computed from instruction semantics, random and directed runs.
module tb_amo_sequencer;

   // ALU codes as defined in riscv_defines.vh
   localparam logic [4:0] C_ADD  = 5'd0;
   localparam logic [4:0] C_XOR  = 5'd4;
   localparam logic [4:0] C_OR   = 5'd6;
   localparam logic [4:0] C_AND  = 5'd7;
   localparam logic [4:0] C_LUI  = 5'd10;
   localparam logic [4:0] C_MIN  = 5'd11;
   localparam logic [4:0] C_MAX  = 5'd12;
   localparam logic [4:0] C_MINU = 5'd13;
   localparam logic [4:0] C_MAXU = 5'd14;

   logic        clk;
   logic        reset;
   logic        start;
   logic [4:0]  funct5;
   logic [31:0] addr;
   logic [31:0] rs2_data;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rd_data;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [4:0]  alu_ctrl;
   logic [31:0] alu_result;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_lock;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [64];
   int          rd_wait = 0;
   int          wr_wait = 0;
   logic [31:0] log_addr [$];
   logic [3:0]  log_wstrb [$];
   logic [31:0] log_wdata [$];

   amo_sequencer #(.ALU_CTRL_W(5)) dut (
      .clk(clk), .reset(reset), .start(start), .funct5(funct5), .addr(addr),
      .rs2_data(rs2_data), .busy(busy), .done(done), .err(err), .rd_data(rd_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_lock(mem_lock),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Shared ALU stand-in
   always_comb begin
      case (alu_ctrl)
         C_ADD:   alu_result = alu_a + alu_b;
         C_XOR:   alu_result = alu_a ^ alu_b;
         C_OR:    alu_result = alu_a | alu_b;
         C_AND:   alu_result = alu_a & alu_b;
         C_LUI:   alu_result = alu_b;
         C_MIN:   alu_result = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
         C_MAX:   alu_result = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
         C_MINU:  alu_result = (alu_a < alu_b) ? alu_a : alu_b;
         C_MAXU:  alu_result = (alu_a > alu_b) ? alu_a : alu_b;
         default: alu_result = 32'h0;
      endcase
   end

   assign mem_rdata = mem[mem_addr[7:2]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit is_legal(input logic [4:0] f5);
      return f5 inside {5'b00001, 5'b00000, 5'b00100, 5'b01100, 5'b01000,
                        5'b10000, 5'b10100, 5'b11000, 5'b11100};
   endfunction

   // Value an AMO stores, from the instruction's definition
   function automatic logic [31:0] ref_new(input logic [4:0] f5, input logic [31:0] o,
                                           input logic [31:0] b);
      case (f5)
         5'b00001: return b;
         5'b00000: return o + b;
         5'b00100: return o ^ b;
         5'b01100: return o & b;
         5'b01000: return o | b;
         5'b10000: return ($signed(o) < $signed(b)) ? o : b;
         5'b10100: return ($signed(o) < $signed(b)) ? b : o;
         5'b11000: return (o < b) ? o : b;
         5'b11100: return (o < b) ? b : o;
         default:  return o;
      endcase
   endfunction

   // Memory responder: programmable wait states, logs handshakes, checks hold stability
   initial begin
      int          cnt;
      int          lim;
      bit          prev_wait;
      logic [31:0] p_addr;
      logic [3:0]  p_wstrb;
      logic [31:0] p_wdata;
      mem_ready = 1'b0;
      cnt = 0;
      prev_wait = 1'b0;
      p_addr = 32'h0;
      p_wstrb = 4'h0;
      p_wdata = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_valid) begin
            if (prev_wait) begin
               chk("hold_addr", mem_addr, p_addr);
               chk("hold_wstrb", {28'h0, mem_wstrb}, {28'h0, p_wstrb});
               chk("hold_wdata", mem_wdata, p_wdata);
            end
            lim = (mem_wstrb == 4'hF) ? wr_wait : rd_wait;
            if (cnt >= lim) begin
               mem_ready = 1'b1;
               log_addr.push_back(mem_addr);
               log_wstrb.push_back(mem_wstrb);
               log_wdata.push_back(mem_wdata);
               if (mem_wstrb == 4'hF) mem[mem_addr[7:2]] = mem_wdata;
               cnt = 0;
               prev_wait = 1'b0;
            end else begin
               mem_ready = 1'b0;
               cnt++;
               prev_wait = 1'b1;
               p_addr = mem_addr;
               p_wstrb = mem_wstrb;
               p_wdata = mem_wdata;
            end
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
            cnt = 0;
            prev_wait = 1'b0;
         end
      end
   end

   // One AMO from launch to the idle cycle after done, fully checked
   task automatic do_amo(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] memval, input int rw, input int ww, input bit poke);
      bit          bad;
      int          lat;
      int          done_at;
      int          lock_cnt;
      logic [31:0] exp_new;
      bad = !is_legal(f5) || (a[1:0] != 2'b00);
      lat = bad ? 1 : 4 + rw + ww;
      exp_new = ref_new(f5, memval, b);
      mem[a[7:2]] = memval;
      rd_wait = rw;
      wr_wait = ww;
      log_addr.delete();
      log_wstrb.delete();
      log_wdata.delete();
      @(negedge clk);
      funct5 = f5;
      addr = a;
      rs2_data = b;
      start = 1'b1;
      done_at = 0;
      lock_cnt = 0;
      for (int k = 1; k <= 60 && done_at == 0; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (poke && k == 2) begin
            start = 1'b1;
            addr = a ^ 32'h40;
            funct5 = 5'b00000;
         end
         if (poke && k == 3) start = 1'b0;
         if (mem_lock) lock_cnt++;
         if (done) begin
            done_at = k;
            chk("err", {31'h0, err}, {31'h0, bad});
            chk("rd_data", rd_data, bad ? 32'h0 : memval);
            chk("busy_in_done", {31'h0, busy}, 32'h1);
         end
      end
      chk("latency", done_at, lat);
      chk("lock_cycles", lock_cnt, bad ? 0 : lat - 1);
      chk("handshakes", log_addr.size(), bad ? 0 : 2);
      if (!bad && log_addr.size() == 2) begin
         chk("rd_addr", log_addr[0], {a[31:2], 2'b00});
         chk("rd_wstrb", {28'h0, log_wstrb[0]}, 32'h0);
         chk("wr_addr", log_addr[1], {a[31:2], 2'b00});
         chk("wr_wstrb", {28'h0, log_wstrb[1]}, 32'hF);
         chk("wr_data", log_wdata[1], exp_new);
      end
      chk("mem_word", mem[a[7:2]], bad ? memval : exp_new);
      @(negedge clk);
      chk("idle_after", {28'h0, busy, done, mem_valid, mem_lock}, 32'h0);
   endtask

   logic [4:0] legal_f5 [9] = '{5'b00001, 5'b00000, 5'b00100, 5'b01100, 5'b01000,
                                5'b10000, 5'b10100, 5'b11000, 5'b11100};

   initial begin
      logic [4:0]  f5;
      logic [31:0] a;
      logic [31:0] m;
      int          d1;
      int          d2;
      int          nd;
      bit          found;
      reset = 1'b1;
      start = 1'b0;
      funct5 = 5'h0;
      addr = 32'h0;
      rs2_data = 32'h0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {23'h0, busy, done, err, mem_valid, mem_lock, mem_wstrb}, 32'h0);
      chk("rst_rd_data", rd_data, 32'h0);
      chk("rst_alu_a", alu_a, 32'h0);
      chk("rst_alu_b", alu_b, 32'h0);
      chk("rst_alu_ctrl", {27'h0, alu_ctrl}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      reset = 1'b0;

      // Directed cases
      do_amo(5'b00000, 32'h100, 32'd7, 32'd5, 0, 0, 1'b0);
      do_amo(5'b10000, 32'h104, 32'd2, 32'hFFFFFFFD, 0, 0, 1'b0);
      do_amo(5'b11000, 32'h108, 32'd2, 32'hFFFFFFFD, 0, 0, 1'b0);
      do_amo(5'b11100, 32'h10C, 32'd2, 32'hFFFFFFFD, 0, 0, 1'b0);
      do_amo(5'b10100, 32'h110, 32'd2, 32'hFFFFFFFD, 0, 0, 1'b0);
      do_amo(5'b00001, 32'h114, 32'hDEADBEEF, 32'h12345678, 0, 0, 1'b0);
      do_amo(5'b00100, 32'h118, 32'h0F0F0F0F, 32'h3C3C3C3C, 3, 2, 1'b0);
      do_amo(5'b00000, 32'h102, 32'd1, 32'h55, 0, 0, 1'b0);
      do_amo(5'b00010, 32'h120, 32'd1, 32'h66, 0, 0, 1'b0);
      do_amo(5'b00000, 32'h124, 32'd3, 32'd10, 1, 1, 1'b1);

      // start held high: two back-to-back sequences, one idle cycle apart
      mem[6'h0A] = 32'd100;
      rd_wait = 0;
      wr_wait = 0;
      @(negedge clk);
      funct5 = 5'b00000;
      addr = 32'h28;
      rs2_data = 32'd9;
      start = 1'b1;
      d1 = 0;
      d2 = 0;
      nd = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (nd == 1) d1 = k;
            else d2 = k;
         end
         if (k == 9) start = 1'b0;
      end
      chk("b2b_first", d1, 4);
      chk("b2b_second", d2, 9);
      chk("b2b_count", nd, 2);
      chk("b2b_mem", mem[6'h0A], 32'd118);
      chk("b2b_rd_data", rd_data, 32'd109);

      // Reset while waiting in WRITE
      mem[6'h20] = 32'h11;
      rd_wait = 0;
      wr_wait = 1000;
      @(negedge clk);
      funct5 = 5'b00000;
      addr = 32'h80;
      rs2_data = 32'd5;
      start = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (mem_valid && mem_wstrb == 4'hF) found = 1'b1;
      end
      chk("reach_write", {31'h0, found}, 32'h1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid", {28'h0, busy, mem_valid, mem_lock, done}, 32'h0);
      chk("rst_mid_mem", mem[6'h20], 32'h11);
      reset = 1'b0;
      wr_wait = 0;
      do_amo(5'b00000, 32'h80, 32'd7, 32'h11, 0, 0, 1'b0);

      // Randomized AMOs
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) f5 = 5'($urandom_range(0, 31));
         else f5 = legal_f5[$urandom_range(0, 8)];
         a = $urandom;
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
         case ($urandom_range(0, 3))
            0:       m = 32'hFFFFFFFF;
            1:       m = 32'h80000000;
            default: m = $urandom;
         endcase
         do_amo(f5, a, $urandom, m, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/amo_sequencer.md
Name: amo_sequencer

Overview:
- Multi-cycle sequencer for RV32A AMO instructions: AMOSWAP, AMOADD, AMOXOR, AMOAND, AMOOR, AMOMIN, AMOMAX, AMOMINU, AMOMAXU.
- Performs an atomic read-modify-write: word read, combine in the shared ALU, word write. Returns the original memory value for rd.
- Sits beside the execute stage. It drives the existing alu instance's a/b/alucontrol inputs while busy, and owns the data-memory port for the whole sequence.

Parameters:
- ALU_CTRL_W, `ALU_CTRL_WIDTH: width of alu_ctrl; codes taken from riscv_defines.vh.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch request; sampled only in IDLE.
- funct5  input  5  AMO funct5 field (instr[31:27]).
- addr  input  32  effective address (rs1).
- rs2_data  input  32  operand from rs2.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done: misaligned address or illegal funct5.
- rd_data  output  32  original memory word; valid while done=1 and held until the next done.
- alu_a  output  32  to alu.a.
- alu_b  output  32  to alu.b.
- alu_ctrl  output  ALU_CTRL_W  to alu.alucontrol.
- alu_result  input  32  from alu.result.
- mem_valid  output  1  memory request.
- mem_ready  input  1  memory accept/complete.
- mem_lock  output  1  bus lock, held for the whole read-through-write sequence.
- mem_addr  output  32  word address.
- mem_wstrb  output  4  0 for read, 4'hF for write.
- mem_wdata  output  32  write data.
- mem_rdata  input  32  read data.

Behaviour:
- Reset values (sampled on clk edge with reset=1):
  - state IDLE.
  - busy, done, err, mem_valid, mem_lock all 0.
  - mem_wstrb 0.
  - rd_data, all internal registers, alu_* and mem_addr/wdata outputs 0.
- Reset mid-sequence abandons any outstanding memory transaction. mem_valid is low in the cycle after the reset edge.
- FSM states: IDLE, READ, CALC, WRITE, DONE.
- IDLE:
  - On start=1, latch addr, rs2_data and the decoded alu_ctrl into registers.
  - If addr[1:0]!=0 or funct5 is illegal, go to DONE with err flag set; no memory access occurs.
  - Otherwise go to READ.
  - start is ignored in every other state.
- funct5 to ALU code mapping:
  - 00001 SWAP -> ALU_CTRL_LUI (result=b).
  - 00000 ADD -> ALU_CTRL_ADD_ADDI.
  - 00100 XOR -> ALU_CTRL_XOR_XORI.
  - 01100 AND -> ALU_CTRL_AND_ANDI.
  - 01000 OR -> ALU_CTRL_OR_ORI.
  - 10000 MIN -> ALU_CTRL_MIN.
  - 10100 MAX -> ALU_CTRL_MAX.
  - 11000 MINU -> ALU_CTRL_MINU.
  - 11100 MAXU -> ALU_CTRL_MAXU.
  - Any other funct5 (including LR 00010 and SC 00011) is illegal.
- READ:
  - mem_valid=1, mem_lock=1, mem_wstrb=0, mem_addr={addr_q[31:2],2'b00}.
  - Hold all of these stable until mem_ready=1.
  - On that edge capture mem_rdata into old_q and go to CALC.
- CALC (exactly 1 cycle):
  - mem_valid=0, mem_lock=1.
  - alu_a=old_q, alu_b=rs2_q, alu_ctrl=ctrl_q.
  - Capture alu_result into new_q and go to WRITE.
  - alu_* outputs carry the registered values in all states. The ALU result is consumed only in CALC.
- WRITE:
  - mem_valid=1, mem_lock=1, mem_wstrb=4'hF, mem_wdata=new_q, same mem_addr.
  - Hold until mem_ready=1, then go to DONE.
- DONE (1 cycle):
  - done=1, rd_data=old_q, err=err_flag, mem_lock=0.
  - Next state IDLE. A new start is accepted in the following IDLE cycle.
  - On the error path rd_data is 0 and no memory request was issued.
- mem_ready seen while mem_valid=0 is ignored.
- Latency with zero-wait memory: start sampled at edge 0 gives done=1 in cycle 4. Each wait cycle in READ or WRITE adds 1 cycle.
- Error path: done=err=1 in cycle 1.
- Arithmetic is 32-bit, wrap-around, no overflow flag. Signed and unsigned comparison is done entirely by the ALU.

Test Plan:
- AMOADD, addr 0x100, mem=5, rs2=7, zero-wait -> read at 0x100, write 12 with wstrb F; done in cycle 4 with rd_data=5, err=0; mem_lock high in cycles 1-3.
- AMOMIN mem=0xFFFFFFFD, rs2=2 -> writes 0xFFFFFFFD. AMOMINU same operands -> writes 2. AMOMAXU -> writes 0xFFFFFFFD. AMOSWAP rs2=0xDEADBEEF -> writes 0xDEADBEEF, rd_data=old word.
- AMOXOR with mem_ready delayed 3 cycles in READ and 2 cycles in WRITE -> mem_valid/addr/wstrb/wdata stable throughout waits; done in cycle 9.
- addr 0x102 -> no mem_valid ever; done=err=1 in cycle 1. funct5=00010 -> same response.
- start pulsed while busy -> ignored, only one sequence is performed. start held high -> back-to-back sequences with one IDLE cycle between them.
- reset asserted during WRITE wait -> mem_valid, busy and mem_lock are 0 in the cycle after the reset edge; a subsequent AMOADD completes normally.
